// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_pkg
// Brief  : Shared UART types and frame constants (TX serializer, future RX).
//          Optional build macro: UART_TX_PARITY_EN (adds the even-parity bit).
// Rev    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int SYMBOL_W    = 10;
    localparam int START_BITS  = 1;
    localparam int STOP_BITS   = 1;
`ifdef UART_TX_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif
    localparam int FRAME_BITS  = START_BITS + SYMBOL_W + PARITY_BITS + STOP_BITS;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    function automatic logic even_parity(input logic [SYMBOL_W-1:0] sym);
        return ^sym;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_serializer_if.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_serializer_if
// Brief  : Symbol handshake and serial-line bundle between encoder and TX.
// Rev    : 1.0 - initial release
// ============================================================================
interface uart_tx_serializer_if;
    import uart_pkg::*;

    logic [SYMBOL_W-1:0] tx_d;
    logic                tx_valid;
    logic                tx_ready;
    logic                tx;
    logic                tx_busy;

    modport master (output tx_d, tx_valid, input tx_ready, tx, tx_busy);
    modport slave  (input tx_d, tx_valid, output tx_ready, tx, tx_busy);
endinterface
`default_nettype wire

// File: rtl/uart_tx_serializer_baud_tick_gen.sv
`default_nettype none
// ============================================================================
// Module : baud_tick_gen
// Brief  : Bit-period counter; tick pulses on the last cycle of each bit.
// Rev    : 1.0 - initial release
// ============================================================================
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clear,
    output logic      tick
);
    localparam int                  c_cnt_w = $clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0]  c_last  = c_cnt_w'(CLKS_PER_BIT - 1);

    logic [c_cnt_w-1:0] r_cnt;

    assign tick = (r_cnt == c_last);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_serializer
// Brief  : 10-bit symbol to UART frame (start, 10 data LSB-first, stop).
//          Optional build macro: UART_TX_PARITY_EN (even parity before stop).
// Rev    : 1.0 - initial release
// ============================================================================
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  wire logic             clk,
    input  wire logic             rst,
    uart_tx_serializer_if.slave   bus
);
    uart_state_t         r_state, w_state_next;
    logic [SYMBOL_W-1:0] r_shift, w_shift_next;
    logic [3:0]          r_bit_cnt, w_bit_cnt_next;
    logic                r_tx, w_tx_next;
    logic                w_tick;
    logic                w_handshake;
    logic                w_baud_clear;
`ifdef UART_TX_PARITY_EN
    logic                r_parity, w_parity_next;
`endif

    assign bus.tx_ready = (r_state == IDLE) && !rst;
    assign bus.tx_busy  = (r_state != IDLE);
    assign bus.tx       = r_tx;
    assign w_handshake  = bus.tx_valid && bus.tx_ready;
    // Holding the counter at zero while idle aligns the first bit to the handshake.
    assign w_baud_clear = (r_state == IDLE);

    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .clear (w_baud_clear),
        .tick  (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_tx      <= w_tx_next;
`ifdef UART_TX_PARITY_EN
            r_parity  <= w_parity_next;
`endif
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_cnt_next = r_bit_cnt;
`ifdef UART_TX_PARITY_EN
        w_parity_next  = r_parity;
`endif
        unique case (r_state)
            IDLE: begin
                if (w_handshake) begin
                    w_state_next   = START;
                    w_shift_next   = bus.tx_d;
                    w_bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
                    w_parity_next  = even_parity(bus.tx_d);
`endif
                end
            end
            START: begin
                if (w_tick) w_state_next = DATA;
            end
            DATA: begin
                if (w_tick) begin
                    w_shift_next = {1'b0, r_shift[SYMBOL_W-1:1]};
                    if (r_bit_cnt == 4'(SYMBOL_W - 1)) begin
                        w_bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
                        w_state_next   = PARITY;
`else
                        w_state_next   = STOP;
`endif
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 4'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (w_tick) w_state_next = STOP;
            end
`endif
            STOP: begin
                if (w_tick) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase

        // Line level is computed from the next state so tx leaves a flop in step with state.
        w_tx_next = 1'b1;
        unique case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  w_tx_next = r_parity;
`endif
            default: w_tx_next = 1'b1;
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_tx_serializer
// Brief  : Scoreboard bench for uart_tx_serializer at CLKS_PER_BIT = 4.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_serializer;
    localparam int C = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_CYC = 13 * C;
`else
    localparam int FRAME_CYC = 12 * C;
`endif

    bit   clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   cyc;
    int   busy_cnt;
    int   frames_done;
    bit   exp_q[$];
    int   hs_q[$];

    uart_tx_serializer_if bus_if ();

    uart_tx_serializer #(
        .CLKS_PER_BIT (C)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_frame(input logic [9:0] d);
        int ones;
        ones = 0;
        for (int k = 0; k < C; k++) exp_q.push_back(1'b0);
        for (int b = 0; b < 10; b++) begin
            if (d[b]) ones++;
            for (int k = 0; k < C; k++) exp_q.push_back(d[b]);
        end
`ifdef UART_TX_PARITY_EN
        for (int k = 0; k < C; k++) exp_q.push_back((ones % 2) == 1);
`endif
        for (int k = 0; k < C; k++) exp_q.push_back(1'b1);
    endtask

    // Cycle-by-cycle line monitor against the scoreboard.
    always @(negedge clk) begin
        bit exp_busy;
        bit e;
        exp_busy = (exp_q.size() != 0);
        check("tx_busy", bus_if.tx_busy, exp_busy);
        if (exp_busy) begin
            e = exp_q.pop_front();
            check("tx_bit", bus_if.tx, e);
        end else begin
            check("tx_idle", bus_if.tx, 1'b1);
        end
        check("tx_ready", bus_if.tx_ready, !exp_busy && !rst);

        if (bus_if.tx_busy) begin
            busy_cnt++;
        end else if (busy_cnt != 0) begin
            check("frame_len", busy_cnt, FRAME_CYC);
            frames_done++;
            busy_cnt = 0;
        end

        if (rst) begin
            exp_q.delete();
            busy_cnt = 0;
        end else if (bus_if.tx_valid && bus_if.tx_ready) begin
            push_frame(bus_if.tx_d);
            hs_q.push_back(cyc);
        end
    end

    task automatic wait_ready();
        bit ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus_if.tx_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("ready_timeout", 0, 1);
    endtask

    task automatic send(input logic [9:0] d);
        bus_if.tx_d     = d;
        bus_if.tx_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        #1 bus_if.tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!bus_if.tx_busy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n0;
        n_checks        = 0;
        n_errors        = 0;
        busy_cnt        = 0;
        frames_done     = 0;
        rst             = 1'b1;
        bus_if.tx_d     = '0;
        bus_if.tx_valid = 1'b0;

        // Reset held for three cycles
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", bus_if.tx_ready, 1'b1);
        @(posedge clk);
        #1;

        // Single frame
        send(10'b0100_100111);
        wait_idle();

        // Back-to-back with tx_valid held high
        n0 = hs_q.size();
        bus_if.tx_d     = 10'h3FF;
        bus_if.tx_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        #1 bus_if.tx_d = 10'h000;
        wait_ready();
        @(posedge clk);
        #1 bus_if.tx_valid = 1'b0;
        if (hs_q.size() >= n0 + 2)
            check("b2b_gap", hs_q[n0+1] - hs_q[n0], FRAME_CYC + 1);
        else
            check("b2b_handshakes", hs_q.size() - n0, 2);
        wait_idle();

        // Ignored input mid-frame
        send(10'h2A5);
        repeat (10) @(posedge clk);
        #1;
        bus_if.tx_d     = 10'h155;
        bus_if.tx_valid = 1'b1;
        @(posedge clk);
        #1 bus_if.tx_valid = 1'b0;
        wait_idle();

        // Reset during data bit 4, then a clean frame
        send(10'h1C3);
        repeat (21) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_tx", bus_if.tx, 1'b1);
        check("abort_busy", bus_if.tx_busy, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(10'h0F1);
        wait_idle();

        // A few arbitrary symbols
        for (int i = 0; i < 3; i++) begin
            send(10'($urandom_range(0, 1023)));
            wait_idle();
        end

        check("frames_done", frames_done, 8);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
